// File: rtl/umi_host_regif_pkg.sv
// Shared UMI message constants (opcodes, command bit layout) and local
// error codes for the host register-access initiator.
package umi_host_regif_pkg;

    localparam logic [4:0] UMI_REQ_READ   = 5'h01;
    localparam logic [4:0] UMI_REQ_WRITE  = 5'h03;
    localparam logic [4:0] UMI_REQ_POSTED = 5'h05;
    localparam logic [4:0] UMI_RESP_READ  = 5'h02;
    localparam logic [4:0] UMI_RESP_WRITE = 5'h04;

    // Command word field positions
    localparam int UMI_OPC_LSB  = 0;
    localparam int UMI_SIZE_LSB = 5;
    localparam int UMI_LEN_LSB  = 8;
    localparam int UMI_EOM_BIT  = 22;
    localparam int UMI_EOF_BIT  = 23;
    localparam int UMI_ERR_LSB  = 25;

    localparam logic [1:0] HOST_ERR_OK      = 2'b00;
    localparam logic [1:0] HOST_ERR_DECODE  = 2'b10;
    localparam logic [1:0] HOST_ERR_TIMEOUT = 2'b11;

    // posted only matters for writes
    function automatic logic [4:0] req_opcode(input logic write, input logic posted);
        if (!write) begin
            return UMI_REQ_READ;
        end
        if (posted) begin
            return UMI_REQ_POSTED;
        end
        return UMI_REQ_WRITE;
    endfunction

endpackage

// File: rtl/umi_pack.sv
// Builds a UMI command word from its individual fields; fields not
// driven here are zero.
module umi_pack
    import umi_host_regif_pkg::*;
#(
    parameter int CW = 32
) (
    input  logic [4:0]    opcode_i,
    input  logic [2:0]    size_i,
    input  logic [7:0]    len_i,
    input  logic          eom_i,
    input  logic          eof_i,
    output logic [CW-1:0] cmd_o
);

    always_comb begin
        cmd_o = '0;
        cmd_o[UMI_OPC_LSB +: 5]  = opcode_i;
        cmd_o[UMI_SIZE_LSB +: 3] = size_i;
        cmd_o[UMI_LEN_LSB +: 8]  = len_i;
        cmd_o[UMI_EOM_BIT]       = eom_i;
        cmd_o[UMI_EOF_BIT]       = eof_i;
    end

endmodule

// File: rtl/umi_unpack.sv
// Extracts the opcode and error field from a UMI response command word.
module umi_unpack
    import umi_host_regif_pkg::*;
#(
    parameter int CW = 32
) (
    input  logic [CW-1:0] cmd_i,
    output logic [4:0]    opcode_o,
    output logic [1:0]    err_o
);

    assign opcode_o = cmd_i[UMI_OPC_LSB +: 5];
    assign err_o    = cmd_i[UMI_ERR_LSB +: 2];

    logic unused_cmd;
    assign unused_cmd = ^cmd_i;

endmodule

// File: rtl/umi_host_regif.sv
// Single-outstanding UMI host initiator: turns one local register access
// into a single-beat UMI request and waits (with timeout) for its response.
module umi_host_regif
    import umi_host_regif_pkg::*;
#(
    parameter int            CW      = 32,
    parameter int            AW      = 64,
    parameter int            DW      = 256,
    parameter int            RW      = 64,
    parameter logic [AW-1:0] SRCADDR = '0,
    parameter int            TIMEOUT = 1024
) (
    input  logic          clk,
    input  logic          nreset,
    input  logic          host_valid,
    input  logic          host_write,
    input  logic          host_posted,
    input  logic [AW-1:0] host_addr,
    input  logic [2:0]    host_size,
    input  logic [RW-1:0] host_wrdata,
    output logic          host_ready,
    output logic          host_done,
    output logic [RW-1:0] host_rdata,
    output logic [1:0]    host_err,
    output logic          uhost_req_valid,
    output logic [CW-1:0] uhost_req_cmd,
    output logic [AW-1:0] uhost_req_dstaddr,
    output logic [AW-1:0] uhost_req_srcaddr,
    output logic [DW-1:0] uhost_req_data,
    input  logic          uhost_req_ready,
    input  logic          uhost_resp_valid,
    input  logic [CW-1:0] uhost_resp_cmd,
    input  logic [AW-1:0] uhost_resp_dstaddr,
    input  logic [AW-1:0] uhost_resp_srcaddr,
    input  logic [DW-1:0] uhost_resp_data,
    output logic          uhost_resp_ready
);

    if (DW < RW) begin : g_bad_dw
        $error("umi_host_regif: DW must be >= RW");
    end

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam int            TW         = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [2:0]    MAX_SIZE   = 3'($clog2(RW / 8));

    logic [1:0]    state_q, state_d;
    logic          wr_q, wr_d;
    logic          posted_q, posted_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [2:0]    size_q, size_d;
    logic [RW-1:0] wdata_q, wdata_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [RW-1:0] rdata_q, rdata_d;
    logic [1:0]    err_q, err_d;

    logic [CW-1:0] req_cmd;
    logic [4:0]    resp_opc;
    logic [1:0]    resp_err;
    logic          size_bad;
    logic          resp_match;
    logic          timeout_hit;

    umi_pack #(.CW(CW)) u_pack (
        .opcode_i (req_opcode(wr_q, posted_q)),
        .size_i   (size_q),
        .len_i    (8'd0),
        .eom_i    (1'b1),
        .eof_i    (1'b1),
        .cmd_o    (req_cmd)
    );

    umi_unpack #(.CW(CW)) u_unpack (
        .cmd_i    (uhost_resp_cmd),
        .opcode_o (resp_opc),
        .err_o    (resp_err)
    );

    assign size_bad    = host_size > MAX_SIZE;
    assign resp_match  = uhost_resp_valid
                         && (resp_opc == (wr_q ? UMI_RESP_WRITE : UMI_RESP_READ))
                         && (uhost_resp_dstaddr == SRCADDR);
    assign timeout_hit = (TIMEOUT != 0) && (timer_q == TIMER_LAST);

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (host_valid) state_d = size_bad ? S_DONE : S_REQ;
            S_REQ:  if (uhost_req_ready) state_d = (wr_q && posted_q) ? S_DONE : S_WAIT;
            S_WAIT: if (resp_match || timeout_hit) state_d = S_DONE;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        host_ready        = 1'b0;
        host_done         = 1'b0;
        uhost_req_valid   = 1'b0;
        uhost_req_cmd     = '0;
        uhost_req_dstaddr = '0;
        uhost_req_data    = '0;
        case (state_q)
            S_IDLE: host_ready = 1'b1;
            S_REQ: begin
                uhost_req_valid   = 1'b1;
                uhost_req_cmd     = req_cmd;
                uhost_req_dstaddr = addr_q;
                uhost_req_data    = wr_q ? DW'(wdata_q) : '0;
            end
            S_DONE: host_done = 1'b1;
            default: ;
        endcase
    end

    // Transaction context and result registers
    always_comb begin
        wr_d     = wr_q;
        posted_d = posted_q;
        addr_d   = addr_q;
        size_d   = size_q;
        wdata_d  = wdata_q;
        timer_d  = timer_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        case (state_q)
            S_IDLE: begin
                if (host_valid) begin
                    wr_d     = host_write;
                    posted_d = host_posted;
                    addr_d   = host_addr;
                    size_d   = host_size;
                    wdata_d  = host_wrdata;
                    rdata_d  = '0;
                    err_d    = size_bad ? HOST_ERR_DECODE : HOST_ERR_OK;
                end
            end
            S_REQ: timer_d = '0;
            S_WAIT: begin
                if (timer_q != '1) timer_d = timer_q + 1'b1;
                // a match in the timeout cycle still completes normally
                if (resp_match) begin
                    rdata_d = wr_q ? '0 : uhost_resp_data[RW-1:0];
                    err_d   = resp_err;
                end else if (timeout_hit) begin
                    err_d = HOST_ERR_TIMEOUT;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            wr_q     <= 1'b0;
            posted_q <= 1'b0;
            addr_q   <= '0;
            size_q   <= '0;
            wdata_q  <= '0;
            timer_q  <= '0;
            rdata_q  <= '0;
            err_q    <= '0;
        end else begin
            wr_q     <= wr_d;
            posted_q <= posted_d;
            addr_q   <= addr_d;
            size_q   <= size_d;
            wdata_q  <= wdata_d;
            timer_q  <= timer_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    assign host_rdata        = rdata_q;
    assign host_err          = err_q;
    assign uhost_req_srcaddr = SRCADDR;
    // Always sink responses so stale or late beats never back up the network
    assign uhost_resp_ready  = 1'b1;

    logic unused_resp;
    assign unused_resp = ^{uhost_resp_srcaddr, uhost_resp_data};

endmodule
